// File: rtl/avr_spi_regbank_if.sv
// AVR SPI pin bundle: the AVR drives chip select, clock and data in,
// the register bank drives data back out.
interface avr_spi_regbank_if;
    logic spics_n;
    logic spick;
    logic spido;
    logic spidi;

    modport master (output spics_n, output spick, output spido, input spidi);
    modport slave  (input spics_n, input spick, input spido, output spidi);
endinterface

// File: rtl/avr_spi_regbank.sv
// AVR SPI register bank: 8-bit LSB-first register number, then a DW-bit
// data phase that reads back rd_data[ch] and writes wr_data[ch] on commit.

// One write channel: holds its word and pulses stb on the cycle it updates.
module avr_spi_regbank_ch #(
    parameter int DW = 16
) (
    input  logic          fclk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          stb
);
    // Capture the received word and strobe together so they line up.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            stb  <= 1'b0;
        end else begin
            stb <= wr_en;
            if (wr_en) dout <= din;
        end
    end
endmodule

module avr_spi_regbank #(
    parameter int         NCH       = 8,
    parameter int         DW        = 16,
    parameter logic [7:0] BASE      = 8'h70,
    parameter bit         LSB_FIRST = 1'b1
) (
    input  logic                  fclk,
    input  logic                  rst_n,
    avr_spi_regbank_if.slave      spi,
    input  logic [7:0]            status_in,
    input  logic [NCH*DW-1:0]     rd_data,
    output logic [NCH*DW-1:0]     wr_data,
    output logic [NCH-1:0]        wr_stb,
    output logic                  err_stb
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BCW = $clog2(DW + 2);

    typedef enum logic [1:0] {ADDR, DATA, COMMIT} state_t;

    state_t                    state, state_n;
    logic [2:0]                cs_sr, ck_sr;
    logic [1:0]                do_sr;
    logic                      cs_hi, cs_fall, cs_rise, sck_rise, sdo;
    logic [7:0]                regnum;
    logic [DW-1:0]             shift_out, in_sh, rd_sel;
    logic [BCW-1:0]            bitcnt;
    logic [CHW-1:0]            ch, ch_dec;
    logic                      valid, addr_ok, do_wr, do_err;
    logic [NCH-1:0]            wr_en;
    logic [NCH-1:0][DW-1:0]    rd_arr, wd_arr;

    assign rd_arr  = rd_data;
    assign wr_data = wd_arr;

    // Two-flop resync of the SPI pins plus a third flop on CS/SCK for edges.
    // Reset to 0 so a CS held low across reset release is not seen as a fall.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sr <= '0;
            ck_sr <= '0;
            do_sr <= '0;
        end else begin
            cs_sr <= {cs_sr[1:0], spi.spics_n};
            ck_sr <= {ck_sr[1:0], spi.spick};
            do_sr <= {do_sr[0], spi.spido};
        end
    end

    assign cs_hi    = cs_sr[1];
    assign cs_fall  = cs_sr[2] & ~cs_sr[1];
    assign cs_rise  = ~cs_sr[2] & cs_sr[1];
    // A CS edge in the same cycle swallows the sck rise.
    assign sck_rise = ~ck_sr[2] & ck_sr[1] & ~cs_fall & ~cs_rise;
    assign sdo      = do_sr[1];

    // Register-number decode; ch is only meaningful when addr_ok is set.
    assign addr_ok = ({1'b0, regnum} >= {1'b0, BASE}) &&
                     ({1'b0, regnum} <  ({1'b0, BASE} + 9'(NCH)));
    assign ch_dec  = CHW'(regnum - BASE);

    // Readback word for the decoded channel, zero for an unmapped register.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NCH; i++)
            if (addr_ok && ch_dec == CHW'(i)) rd_sel = rd_arr[i];
    end

    // State register.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) state <= ADDR;
        else        state <= state_n;
    end

    // Next state: CS fall opens the data phase, CS rise commits for one cycle.
    always_comb begin
        state_n = state;
        case (state)
            ADDR:    if (cs_fall) state_n = DATA;
            DATA:    if (cs_rise) state_n = COMMIT;
            default: state_n = ADDR;
        endcase
    end

    // Address/data shifters, bit counter and latched channel decode.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            regnum    <= '0;
            shift_out <= '0;
            in_sh     <= '0;
            bitcnt    <= '0;
            ch        <= '0;
            valid     <= 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (cs_rise) begin
                        regnum    <= '0;
                        shift_out <= DW'(status_in);
                    end else if (cs_fall) begin
                        ch        <= ch_dec;
                        valid     <= addr_ok;
                        bitcnt    <= '0;
                        shift_out <= rd_sel;
                    end else if (sck_rise && cs_hi) begin
                        regnum    <= {sdo, regnum[7:1]};
                        shift_out <= shift_out >> 1;
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        regnum    <= '0;
                        shift_out <= DW'(status_in);
                    end else if (sck_rise) begin
                        if (LSB_FIRST) begin
                            in_sh     <= {sdo, in_sh[DW-1:1]};
                            shift_out <= shift_out >> 1;
                        end else begin
                            in_sh     <= {in_sh[DW-2:0], sdo};
                            shift_out <= shift_out << 1;
                        end
                        if (bitcnt != BCW'(DW + 1)) bitcnt <= bitcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi.spidi = (state == DATA && !LSB_FIRST) ? shift_out[DW-1] : shift_out[0];

    // Commit outcome: exact-length write to a mapped channel, zero-length
    // read is silent, anything else is flagged.
    assign do_wr  = (state == COMMIT) && valid && (bitcnt == BCW'(DW));
    assign do_err = (state == COMMIT) && (bitcnt != '0) && !do_wr;

    // One-hot write enable for the addressed channel.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NCH; i++)
            if (do_wr && ch == CHW'(i)) wr_en[i] = 1'b1;
    end

    // Error strobe registered to line up with the write strobes.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) err_stb <= 1'b0;
        else        err_stb <= do_err;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        avr_spi_regbank_ch #(.DW(DW)) u_ch (
            .fclk  (fclk),
            .rst_n (rst_n),
            .wr_en (wr_en[g]),
            .din   (in_sh),
            .dout  (wd_arr[g]),
            .stb   (wr_stb[g])
        );
    end
endmodule
